// File: rtl/mem_rw_sched.sv
// Read/write scheduler: shares one DDR controller burst port between the
// write arbiter and the read arbiter, one burst at a time. It alternates
// direction on ties and inserts a turnaround gap after every burst.
// Optional watchdog: define MEM_RW_SCHED_WDOG_EN to abort bursts that
// never finish.
module mem_rw_sched #(
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned ADDR_BITS     = 25,
  parameter int unsigned TURN_CYCLES   = 2,
  parameter int unsigned WDOG_CYCLES   = 8000
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     wr_burst_req,
  input  logic [9:0]               wr_burst_len,
  input  logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic                     wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
  output logic                     wr_burst_finish,
  input  logic                     rd_burst_req,
  input  logic [9:0]               rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic                     rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_finish,
  output logic                     ctl_wr_burst_req,
  output logic [9:0]               ctl_wr_burst_len,
  output logic [ADDR_BITS-1:0]     ctl_wr_burst_addr,
  input  logic                     ctl_wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] ctl_wr_burst_data,
  input  logic                     ctl_wr_burst_finish,
  output logic                     ctl_rd_burst_req,
  output logic [9:0]               ctl_rd_burst_len,
  output logic [ADDR_BITS-1:0]     ctl_rd_burst_addr,
  input  logic                     ctl_rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] ctl_rd_burst_data,
  input  logic                     ctl_rd_burst_finish,
  output logic                     err_len,
  output logic                     err_timeout
);

  if (TURN_CYCLES == 0 || TURN_CYCLES > 15 || WDOG_CYCLES == 0 || WDOG_CYCLES > 65535) begin : g_cfg_check
    $error("mem_rw_sched: TURN_CYCLES must be 1..15 and WDOG_CYCLES 1..65535");
  end

  typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT, TURN} state_e;

  state_e                 state_q, state_d;
  logic                   last_wr_q, last_wr_d;
  logic                   ctl_wr_req_q, ctl_wr_req_d;
  logic                   ctl_rd_req_q, ctl_rd_req_d;
  logic [9:0]             wr_len_q, wr_len_d, rd_len_q, rd_len_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [9:0]             beat_q, beat_d;
  logic [3:0]             turn_q, turn_d;
  logic                   err_len_q, err_len_d;

  logic wr_pend, rd_pend, wr_act, rd_act, wr_beat, rd_beat, grant, wdog_fire;
  logic [9:0] beat_now;

  assign wr_pend  = wr_burst_req && (wr_burst_len != '0);
  assign rd_pend  = rd_burst_req && (rd_burst_len != '0);
  assign wr_act   = (state_q == WR_ACT);
  assign rd_act   = (state_q == RD_ACT);
  assign wr_beat  = wr_act && ctl_wr_burst_data_req;
  assign rd_beat  = rd_act && ctl_rd_burst_data_valid;
  // A beat arriving together with finish still counts toward the length check.
  assign beat_now = beat_q + {9'd0, (wr_beat || rd_beat)};

  assign wr_burst_data_req   = wr_beat;
  assign ctl_wr_burst_data   = wr_act ? wr_burst_data : '0;
  assign rd_burst_data_valid = rd_beat;
  assign rd_burst_data       = ctl_rd_burst_data;
  assign wr_burst_finish     = wr_act && (ctl_wr_burst_finish || wdog_fire);
  assign rd_burst_finish     = rd_act && (ctl_rd_burst_finish || wdog_fire);

  assign ctl_wr_burst_req  = ctl_wr_req_q;
  assign ctl_wr_burst_len  = wr_len_q;
  assign ctl_wr_burst_addr = wr_addr_q;
  assign ctl_rd_burst_req  = ctl_rd_req_q;
  assign ctl_rd_burst_len  = rd_len_q;
  assign ctl_rd_burst_addr = rd_addr_q;
  assign err_len           = err_len_q;

`ifdef MEM_RW_SCHED_WDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic        err_to_q, err_to_d;

  assign wdog_fire   = (wr_act || rd_act) && (wdog_q == 16'(WDOG_CYCLES - 1));
  assign err_timeout = err_to_q;

  // Watchdog: restarts on grant, counts active cycles; a real finish in the
  // firing cycle wins and does not flag a timeout.
  always_comb begin
    wdog_d   = wdog_q;
    err_to_d = err_to_q;
    if (grant) wdog_d = '0;
    else if (wr_act || rd_act) wdog_d = wdog_q + 16'd1;
    if (wdog_fire && !(wr_act && ctl_wr_burst_finish) && !(rd_act && ctl_rd_burst_finish))
      err_to_d = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q   <= '0;
      err_to_q <= 1'b0;
    end else begin
      wdog_q   <= wdog_d;
      err_to_q <= err_to_d;
    end
  end
`else
  assign wdog_fire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state: grant arbitration, command latching, beat counting, turnaround.
  always_comb begin
    state_d      = state_q;
    last_wr_d    = last_wr_q;
    ctl_wr_req_d = ctl_wr_req_q;
    ctl_rd_req_d = ctl_rd_req_q;
    wr_len_d     = wr_len_q;
    wr_addr_d    = wr_addr_q;
    rd_len_d     = rd_len_q;
    rd_addr_d    = rd_addr_q;
    beat_d       = beat_q;
    turn_d       = '0;
    err_len_d    = err_len_q;
    grant        = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_pend && (!rd_pend || !last_wr_q)) begin
          grant        = 1'b1;
          state_d      = WR_ACT;
          ctl_wr_req_d = 1'b1;
          wr_len_d     = wr_burst_len;
          wr_addr_d    = wr_burst_addr;
          last_wr_d    = 1'b1;
          beat_d       = '0;
        end else if (rd_pend) begin
          grant        = 1'b1;
          state_d      = RD_ACT;
          ctl_rd_req_d = 1'b1;
          rd_len_d     = rd_burst_len;
          rd_addr_d    = rd_burst_addr;
          last_wr_d    = 1'b0;
          beat_d       = '0;
        end
      end
      WR_ACT: begin
        beat_d = beat_now;
        if (ctl_wr_burst_data_req) ctl_wr_req_d = 1'b0;
        if (ctl_wr_burst_finish) begin
          if (beat_now != wr_len_q) err_len_d = 1'b1;
          ctl_wr_req_d = 1'b0;
          state_d      = TURN;
        end else if (wdog_fire) begin
          ctl_wr_req_d = 1'b0;
          state_d      = TURN;
        end
      end
      RD_ACT: begin
        beat_d = beat_now;
        if (ctl_rd_burst_data_valid) ctl_rd_req_d = 1'b0;
        if (ctl_rd_burst_finish) begin
          if (beat_now != rd_len_q) err_len_d = 1'b1;
          ctl_rd_req_d = 1'b0;
          state_d      = TURN;
        end else if (wdog_fire) begin
          ctl_rd_req_d = 1'b0;
          state_d      = TURN;
        end
      end
      TURN: begin
        if (turn_q == 4'(TURN_CYCLES - 1)) state_d = IDLE;
        else turn_d = turn_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and command registers.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_wr_q    <= 1'b0;
      ctl_wr_req_q <= 1'b0;
      ctl_rd_req_q <= 1'b0;
      wr_len_q     <= '0;
      wr_addr_q    <= '0;
      rd_len_q     <= '0;
      rd_addr_q    <= '0;
      beat_q       <= '0;
      turn_q       <= '0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_wr_q    <= last_wr_d;
      ctl_wr_req_q <= ctl_wr_req_d;
      ctl_rd_req_q <= ctl_rd_req_d;
      wr_len_q     <= wr_len_d;
      wr_addr_q    <= wr_addr_d;
      rd_len_q     <= rd_len_d;
      rd_addr_q    <= rd_addr_d;
      beat_q       <= beat_d;
      turn_q       <= turn_d;
      err_len_q    <= err_len_d;
    end
  end

endmodule

// File: tb/tb_mem_rw_sched.sv
// Scoreboard bench for mem_rw_sched: stimulus pushes expected grants and
// finishes, a negedge monitor pops and compares them as the DUT shows them.
module tb_mem_rw_sched;
  localparam int AW   = 25;
  localparam int DW   = 32;
  localparam int TURN = 2;
  localparam int WDOG = 100;

  logic          mem_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_burst_req = 1'b0, rd_burst_req = 1'b0;
  logic [9:0]    wr_burst_len = '0, rd_burst_len = '0;
  logic [AW-1:0] wr_burst_addr = '0, rd_burst_addr = '0;
  logic [DW-1:0] wr_burst_data = '0, ctl_rd_burst_data = '0;
  logic          ctl_wr_burst_data_req = 1'b0, ctl_wr_burst_finish = 1'b0;
  logic          ctl_rd_burst_data_valid = 1'b0, ctl_rd_burst_finish = 1'b0;
  logic          wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish;
  logic [DW-1:0] rd_burst_data, ctl_wr_burst_data;
  logic          ctl_wr_burst_req, ctl_rd_burst_req, err_len, err_timeout;
  logic [9:0]    ctl_wr_burst_len, ctl_rd_burst_len;
  logic [AW-1:0] ctl_wr_burst_addr, ctl_rd_burst_addr;

  mem_rw_sched #(
    .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .TURN_CYCLES(TURN), .WDOG_CYCLES(WDOG)
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish),
    .ctl_wr_burst_req(ctl_wr_burst_req), .ctl_wr_burst_len(ctl_wr_burst_len),
    .ctl_wr_burst_addr(ctl_wr_burst_addr), .ctl_wr_burst_data_req(ctl_wr_burst_data_req),
    .ctl_wr_burst_data(ctl_wr_burst_data), .ctl_wr_burst_finish(ctl_wr_burst_finish),
    .ctl_rd_burst_req(ctl_rd_burst_req), .ctl_rd_burst_len(ctl_rd_burst_len),
    .ctl_rd_burst_addr(ctl_rd_burst_addr), .ctl_rd_burst_data_valid(ctl_rd_burst_data_valid),
    .ctl_rd_burst_data(ctl_rd_burst_data), .ctl_rd_burst_finish(ctl_rd_burst_finish),
    .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 mem_clk = ~mem_clk;

  localparam int K_GW = 0, K_FW = 1, K_GR = 2, K_FR = 3;
  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [9:0]    len;
    int            beats;
    int            gap;   // -1: not checked
  } exp_t;

  exp_t sbq[$];
  int checks = 0, fails = 0;
  int cyc = 0, last_fin = 0, last_grant = 0;
  int wbeats = 0, rbeats = 0, wfin_cnt = 0, rfin_cnt = 0;
  logic prev_wreq = 1'b0, prev_rreq = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_exp(input int kind, input logic [AW-1:0] addr,
                                   input logic [9:0] len, input int beats, input int gap);
    exp_t e;
    e.kind = kind; e.addr = addr; e.len = len; e.beats = beats; e.gap = gap;
    sbq.push_back(e);
  endfunction

  function automatic void sb_event(input int kind, input logic [AW-1:0] addr,
                                   input logic [9:0] len, input int beats, input int gap);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; fails++;
      $display("FAIL sb_unexpected: got event kind %0d expected none (cycle %0d)", kind, cyc);
      return;
    end
    e = sbq.pop_front();
    check("sb_kind", kind, e.kind);
    if (kind == K_GW || kind == K_GR) begin
      check("grant_addr", addr, e.addr);
      check("grant_len", len, e.len);
    end else begin
      check("finish_beats", beats, e.beats);
    end
    if (e.gap >= 0) check("event_gap", gap, e.gap);
  endfunction

  always @(posedge mem_clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge mem_clk) begin
    if (rst_n) begin
      if (ctl_wr_burst_req || ctl_rd_burst_req)
        check("req_overlap", ctl_wr_burst_req & ctl_rd_burst_req, 0);
      if (ctl_wr_burst_req && !prev_wreq) begin
        sb_event(K_GW, ctl_wr_burst_addr, ctl_wr_burst_len, 0, cyc - last_fin);
        wbeats = 0; last_grant = cyc;
      end
      if (ctl_rd_burst_req && !prev_rreq) begin
        sb_event(K_GR, ctl_rd_burst_addr, ctl_rd_burst_len, 0, cyc - last_fin);
        rbeats = 0; last_grant = cyc;
      end
      if (wr_burst_data_req) begin
        wbeats++;
        check("wr_data_route", ctl_wr_burst_data, wr_burst_data);
      end
      if (rd_burst_data_valid) begin
        rbeats++;
        check("rd_data_route", rd_burst_data, ctl_rd_burst_data);
      end
      if (wr_burst_finish) begin
        sb_event(K_FW, '0, '0, wbeats, cyc - last_grant);
        last_fin = cyc; wfin_cnt++;
      end
      if (rd_burst_finish) begin
        sb_event(K_FR, '0, '0, rbeats, cyc - last_grant);
        last_fin = cyc; rfin_cnt++;
      end
    end
    prev_wreq = ctl_wr_burst_req;
    prev_rreq = ctl_rd_burst_req;
  end

  task automatic tick();
    @(posedge mem_clk); #1;
  endtask

  task automatic wait_grant(input bit wr, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (wr ? ctl_wr_burst_req : ctl_rd_burst_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL grant_wait: got no %s grant expected one within 300 cycles", wr ? "write" : "read");
    end
  endtask

  // Controller model for a write burst; drop[0]/drop[1] release wr/rd requests at grant.
  task automatic serve_wr(input int beats, input bit fin, input logic [1:0] drop);
    bit ok;
    wait_grant(1'b1, ok);
    if (!ok) return;
    if (drop[0]) wr_burst_req = 1'b0;
    if (drop[1]) rd_burst_req = 1'b0;
    for (int i = 0; i < beats; i++) begin
      ctl_wr_burst_data_req = 1'b1;
      wr_burst_data = 32'hA500_0000 + 32'(i);
      tick();
    end
    ctl_wr_burst_data_req = 1'b0;
    if (fin) begin
      ctl_wr_burst_finish = 1'b1; tick(); ctl_wr_burst_finish = 1'b0;
    end
  endtask

  task automatic serve_rd(input int beats, input bit fin, input logic [1:0] drop);
    bit ok;
    wait_grant(1'b0, ok);
    if (!ok) return;
    if (drop[0]) wr_burst_req = 1'b0;
    if (drop[1]) rd_burst_req = 1'b0;
    for (int i = 0; i < beats; i++) begin
      ctl_rd_burst_data_valid = 1'b1;
      ctl_rd_burst_data = 32'h5A00_0000 + 32'(i);
      tick();
    end
    ctl_rd_burst_data_valid = 1'b0;
    if (fin) begin
      ctl_rd_burst_finish = 1'b1; tick(); ctl_rd_burst_finish = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl_req"}, {ctl_wr_burst_req, ctl_rd_burst_req}, 0);
    check({tag, "_ctl_len"}, {ctl_wr_burst_len, ctl_rd_burst_len}, 0);
    check({tag, "_ctl_addr"}, {ctl_wr_burst_addr, ctl_rd_burst_addr}, 0);
    check({tag, "_ctl_wdata"}, ctl_wr_burst_data, 0);
    check({tag, "_up_ctrl"}, {wr_burst_data_req, rd_burst_data_valid, wr_burst_finish, rd_burst_finish}, 0);
    check({tag, "_err"}, {err_len, err_timeout}, 0);
    check({tag, "_rd_pass"}, rd_burst_data, ctl_rd_burst_data);
  endtask

  initial begin
    int wf0, rf0;
    bit seen;
    // Reset state, with live inputs that must not leak through.
    wr_burst_data = 32'hDEAD_BEEF;
    ctl_rd_burst_data = 32'h1234_5678;
    ctl_wr_burst_data_req = 1'b1;
    tick(); tick();
    check_outputs_zero("reset");
    ctl_wr_burst_data_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // Tie from reset: write, read, write; gaps of TURN+2 between bursts.
    push_exp(K_GW, 25'h100, 10'd4, 0, -1);
    push_exp(K_FW, '0, '0, 4, -1);
    push_exp(K_GR, 25'h200, 10'd3, 0, TURN + 2);
    push_exp(K_FR, '0, '0, 3, -1);
    push_exp(K_GW, 25'h100, 10'd4, 0, TURN + 2);
    push_exp(K_FW, '0, '0, 4, -1);
    wr_burst_addr = 25'h100; wr_burst_len = 10'd4; wr_burst_req = 1'b1;
    rd_burst_addr = 25'h200; rd_burst_len = 10'd3; rd_burst_req = 1'b1;
    serve_wr(4, 1'b1, 2'b00);
    serve_rd(3, 1'b1, 2'b00);
    serve_wr(4, 1'b1, 2'b11);
    tick();
    check("tie_err_len", err_len, 0);

    // Write-only len 16, then a read len 8 with only 7 beats.
    wf0 = wfin_cnt; rf0 = rfin_cnt;
    push_exp(K_GW, 25'h3FF0, 10'd16, 0, -1);
    push_exp(K_FW, '0, '0, 16, -1);
    push_exp(K_GR, 25'h0ABC, 10'd8, 0, TURN + 2);
    push_exp(K_FR, '0, '0, 7, -1);
    wr_burst_addr = 25'h3FF0; wr_burst_len = 10'd16; wr_burst_req = 1'b1;
    serve_wr(16, 1'b1, 2'b01);
    check("wr16_err_len", err_len, 0);
    rd_burst_addr = 25'h0ABC; rd_burst_len = 10'd8; rd_burst_req = 1'b1;
    serve_rd(7, 1'b1, 2'b10);
    check("short_rd_err_len", err_len, 1);
    repeat (4) tick();
    check("wr_finish_count", wfin_cnt - wf0, 1);
    check("rd_finish_count", rfin_cnt - rf0, 1);

    // Zero-length requests are never granted.
    wr_burst_len = '0; rd_burst_len = '0;
    wr_burst_req = 1'b1; rd_burst_req = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (ctl_wr_burst_req || ctl_rd_burst_req) seen = 1'b1;
    end
    check("len0_no_grant", seen, 0);
    wr_burst_req = 1'b0; rd_burst_req = 1'b0;
    check("err_len_sticky", err_len, 1);

`ifdef MEM_RW_SCHED_WDOG_EN
    // Write that never finishes: abort after WDOG active cycles, then serve the read.
    check("wdog_err_before", err_timeout, 0);
    push_exp(K_GW, 25'h55, 10'd5, 0, -1);
    push_exp(K_FW, '0, '0, 0, WDOG - 1);
    push_exp(K_GR, 25'h66, 10'd2, 0, TURN + 2);
    push_exp(K_FR, '0, '0, 2, -1);
    wr_burst_addr = 25'h55; wr_burst_len = 10'd5; wr_burst_req = 1'b1;
    serve_wr(0, 1'b0, 2'b01);
    rd_burst_addr = 25'h66; rd_burst_len = 10'd2; rd_burst_req = 1'b1;
    serve_rd(2, 1'b1, 2'b10);
    check("wdog_err_timeout", err_timeout, 1);
    check("wdog_wr_req_dropped", ctl_wr_burst_req, 0);
`else
    check("no_wdog_err_timeout", err_timeout, 0);
`endif

    // Reset in the middle of a read burst.
    rf0 = rfin_cnt;
    push_exp(K_GR, 25'h1F0, 10'd6, 0, -1);
    rd_burst_addr = 25'h1F0; rd_burst_len = 10'd6; rd_burst_req = 1'b1;
    serve_rd(2, 1'b0, 2'b10);
    wr_burst_data = 32'hCAFE_F00D;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    tick(); tick();
    check_outputs_zero("midrst_hold");
    check("midrst_no_finish", rfin_cnt - rf0, 0);
    rst_n = 1'b1;
    tick();
    push_exp(K_GW, 25'h77, 10'd3, 0, -1);
    push_exp(K_FW, '0, '0, 3, -1);
    wr_burst_addr = 25'h77; wr_burst_len = 10'd3; wr_burst_req = 1'b1;
    serve_wr(3, 1'b1, 2'b01);
    check("post_rst_err_len", err_len, 0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test expected one within 500000 time units");
    $fatal(1, "simulation time limit");
  end
endmodule
